lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent waiting for mem_gnt or for mem_rvalid before an error response.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  access request from core.
REQ-005 req_ready  output  1  LSU can accept; high only in IDLE and with rst_n high.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal (same encoding as decoder bit_half_word_select).
REQ-008 req_unsigned  input  1  1 = zero-extend load data, 0 = sign-extend.
REQ-009 req_addr  input  32  byte address (ALU result).
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_error  output  1  misaligned, illegal size or timeout; meaningful only with resp_valid.
REQ-014 mem_req  output  1  memory request, held until mem_gnt.
REQ-015 mem_we  output  1  1 = write access.
REQ-016 mem_addr  output  32  {addr[31:2],2'b00}.
REQ-017 mem_wstrb  output  4  byte-lane enables; 0000 for loads.
REQ-018 mem_wdata  output  32  lane-replicated store data.
REQ-019 mem_gnt  input  1  memory accepted the request.
REQ-020 mem_rvalid  input  1  read data valid.
REQ-021 mem_rdata  input  32  aligned read word.

Function
REQ-022 The LSU SHALL implement states IDLE, REQ, WAIT and RESP; req_valid outside IDLE is ignored.
REQ-023 On req_valid && req_ready, the LSU SHALL register write, size, unsigned, addr and wdata; mem_* outputs come only from registers and stay stable while in REQ.
REQ-024 The LSU SHALL detect an error at accept (size 11; half with addr[0]=1; word with addr[1:0]!=00) and go IDLE->RESP with resp_error=1, never asserting mem_req.
REQ-025 Otherwise IDLE->REQ; REQ asserts mem_req; on mem_gnt a store goes to RESP and a load goes to WAIT.
REQ-026 mem_rvalid SHALL be sampled only in WAIT, never in the gnt cycle; on mem_rvalid the LSU goes WAIT->RESP and registers the extended data.
REQ-027 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-028 Store strobes: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. mem_wdata: byte replicated x4, half replicated x2, word unchanged.
REQ-029 Load extraction: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16]; then sign- or zero-extended per unsigned; for word, unsigned is ignored.
REQ-030 A cycle counter SHALL clear on entry to REQ and to WAIT and increment each cycle in those states; if it reaches TIMEOUT with no handshake, the LSU SHALL drop mem_req, go to RESP with resp_error=1 and resp_rdata=0.
REQ-031 Latency, with accept at cycle k: error response at k+1; store with gnt in cycle k+1 responds at k+2; load with gnt at k+1 and rvalid at k+2 responds at k+3.
REQ-032 A stray mem_rvalid in IDLE, REQ or RESP SHALL be ignored.

Reset
REQ-033 While rst_n is low: state = IDLE; all registers and all outputs = 0 (including req_ready); counter = 0.
REQ-034 Reset mid-transaction SHALL abandon the access: mem_req falls asynchronously and no resp_valid is issued for it.

Verification
REQ-035 Store byte, addr 0x1003, wdata 0xAB, gnt at once -> mem_addr 0x1000, wstrb 1000, wdata 0xABABABAB, resp_valid at k+2, error 0.
REQ-036 Load half signed, addr 0x2002, rdata 0x8001_1234 -> resp_rdata 0xFFFF8001; same load with unsigned=1 -> 0x00008001.
REQ-037 Load word, addr 0x3001 -> resp_valid at k+1, resp_error 1, mem_req never high.
REQ-038 TIMEOUT=4, load with gnt withheld -> mem_req high for 4 cycles, then resp_error 1 and resp_rdata 0.
REQ-039 rst_n pulled low in WAIT -> mem_req 0 immediately, no resp_valid; after release, req_ready 1 and a byte load at 0x0 completes normally.
REQ-040 Back-to-back requests -> req_ready low from accept through RESP; second accept no earlier than the cycle after resp_valid.

Source files
------------

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if -- bundle of the core-side request/response channel and the
// memory-side request/data channel of the load/store unit.
//
//   Core side   : req_valid/req_ready handshake with write, size, unsigned,
//                 addr and wdata qualifiers; resp_valid pulse with rdata/error.
//   Memory side : mem_req held until mem_gnt, with we/addr/wstrb/wdata;
//                 mem_rvalid/mem_rdata return path for loads.
//
// Modports:
//   master -- the environment (core + memory) driving requests and memory
//             responses.
//   slave  -- the LSU itself.
// -----------------------------------------------------------------------------
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- single-outstanding load/store unit.
//
// Accepts one access from the core in IDLE, checks alignment/size, issues a
// word-aligned memory request with byte strobes and lane-replicated store
// data, waits for read data on loads, and returns a one-cycle response with
// sign/zero-extended load data or an error flag (misaligned, illegal size,
// or no handshake within TIMEOUT cycles).
//
// Ports:
//   clk    -- clock, rising edge
//   rst_n  -- asynchronous active-low reset
//   bus    -- lsu_if.slave: core request/response and memory channels
//
// Parameters:
//   TIMEOUT -- cycles allowed in REQ (for mem_gnt) or WAIT (for mem_rvalid)
//              before an error response; must be >= 1.
// -----------------------------------------------------------------------------
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic   clk,
  input logic   rst_n,
  lsu_if.slave  bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state, next_state;

  // Registered request and response fields; every mem_* output comes from here.
  logic             we_q;
  logic [1:0]       size_q;
  logic             unsigned_q;
  logic [1:0]       addr_lo_q;
  logic [31:0]      mem_addr_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic        req_ready, resp_valid, mem_req;
  logic        accept, timeout_hit;
  logic        acc_err;
  logic [3:0]  acc_strb;
  logic [31:0] acc_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign accept      = bus.req_valid && req_ready;
  // Counter holds the number of cycles already spent in REQ/WAIT, so the
  // last permitted cycle is the one where it reads TIMEOUT-1.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Accept-time decode: error detection, byte strobes, lane replication.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    acc_err   = 1'b0;
    acc_strb  = 4'b1111;
    acc_wdata = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        acc_strb  = 4'b0001 << bus.req_addr[1:0];
        acc_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        acc_err   = bus.req_addr[0];
        acc_strb  = 4'b0011 << bus.req_addr[1:0];
        acc_wdata = {2{bus.req_wdata[15:0]}};
      end
      2'b10:   acc_err = |bus.req_addr[1:0];
      default: acc_err = 1'b1;
    endcase
  end

  // Load-data lane extraction and extension from the registered size/offset.
  always_comb begin
    case (addr_lo_q)
      2'b01:   ld_byte = bus.mem_rdata[15:8];
      2'b10:   ld_byte = bus.mem_rdata[23:16];
      2'b11:   ld_byte = bus.mem_rdata[31:24];
      default: ld_byte = bus.mem_rdata[7:0];
    endcase
    ld_half = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_ext = unsigned_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = unsigned_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM: next-state logic. mem_rvalid is looked at only in WAIT.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept) next_state = acc_err ? RESP : REQ;
      REQ: begin
        if (bus.mem_gnt)      next_state = we_q ? RESP : WAIT;
        else if (timeout_hit) next_state = RESP;
      end
      WAIT: if (bus.mem_rvalid || timeout_hit) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM: outputs decoded from state only. req_ready is also gated by rst_n so
  // it is low for the whole reset, not just after the first edge.
  always_comb begin
    req_ready  = (state == IDLE) && rst_n;
    mem_req    = (state == REQ);
    resp_valid = (state == RESP);
  end

  // Cycle counter: cleared on entry to REQ/WAIT, counts while resident there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((next_state == REQ  && state != REQ) ||
                 (next_state == WAIT && state != WAIT)) begin
      cnt_q <= '0;
    end else if (state == REQ || state == WAIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Request capture and response data. rdata is cleared at accept so stores,
  // errors and timeouts all respond with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_lo_q  <= 2'b00;
      mem_addr_q <= '0;
      wstrb_q    <= 4'b0000;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      we_q       <= bus.req_write;
      size_q     <= bus.req_size;
      unsigned_q <= bus.req_unsigned;
      addr_lo_q  <= bus.req_addr[1:0];
      mem_addr_q <= {bus.req_addr[31:2], 2'b00};
      wstrb_q    <= bus.req_write ? acc_strb : 4'b0000;
      wdata_q    <= bus.req_write ? acc_wdata : 32'h0;
      rdata_q    <= '0;
      err_q      <= acc_err;
    end else if (state == WAIT && bus.mem_rvalid) begin
      rdata_q    <= ld_ext;
    end else if (timeout_hit && ((state == REQ  && !bus.mem_gnt) ||
                                 (state == WAIT && !bus.mem_rvalid))) begin
      err_q      <= 1'b1;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = err_q;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wstrb  = wstrb_q;
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- directed self-checking bench for lsu (TIMEOUT = 4).
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// acts on the rising edge. "Cycle k" is the cycle whose rising edge accepts.
// -----------------------------------------------------------------------------
module tb_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  lsu_if bus ();

  lsu #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } st_vec_t;

  typedef struct {
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  task automatic idle_inputs();
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.mem_gnt      = 1'b0;
    bus.mem_rvalid   = 1'b0;
    bus.mem_rdata    = 32'h0;
  endtask

  // Presents one request at the current falling edge (cycle k) and returns at
  // the falling edge of cycle k+1 with req_valid dropped.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready: got %b expected 1 (addr %h)", bus.req_ready, a);
    end
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    @(negedge clk);
    bus.req_valid    = 1'b0;
  endtask

  // Load with grant in k+1 (plus a stray rvalid carrying junk in that same
  // cycle) and real rvalid in k+2; response expected in k+3.
  task automatic run_load(input ld_vec_t v, input string tag);
    issue(1'b0, v.size, v.uns, v.addr, 32'h0);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_wstrb !== 4'b0000) begin
      failures++;
      $display("FAIL %s_req: got req=%b we=%b strb=%b expected req=1 we=0 strb=0000",
               tag, bus.mem_req, bus.mem_we, bus.mem_wstrb);
    end
    checks++;
    if (bus.mem_addr !== {v.addr[31:2], 2'b00}) begin
      failures++;
      $display("FAIL %s_addr: got %h expected %h", tag, bus.mem_addr, {v.addr[31:2], 2'b00});
    end
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_0BAD;
    @(negedge clk);
    bus.mem_gnt    = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_wait: got req=%b resp_valid=%b expected 0 0",
               tag, bus.mem_req, bus.resp_valid);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = v.rdata;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b0 || bus.resp_rdata !== v.exp) begin
      failures++;
      $display("FAIL %s_resp: got valid=%b err=%b rdata=%h expected 1 0 %h",
               tag, bus.resp_valid, bus.resp_error, bus.resp_rdata, v.exp);
    end
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_after: got valid=%b ready=%b expected 0 1",
               tag, bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_error, bus.mem_req, bus.mem_we} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got ready/valid/err/req/we=%b expected 00000",
               {bus.req_ready, bus.resp_valid, bus.resp_error, bus.mem_req, bus.mem_we});
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_wstrb !== 4'h0 ||
        bus.resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wdata=%h strb=%b rdata=%h expected zeros",
               bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.resp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready);
    end
  endtask

  task automatic test_store();
    st_vec_t v[4];
    v[0] = '{2'b00, 32'h0000_1003, 32'h0000_00AB, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB};
    v[1] = '{2'b00, 32'h0000_1001, 32'h1234_5655, 32'h0000_1000, 4'b0010, 32'h5555_5555};
    v[2] = '{2'b01, 32'h0000_1002, 32'h1234_ABCD, 32'h0000_1000, 4'b1100, 32'hABCD_ABCD};
    v[3] = '{2'b10, 32'h0000_1004, 32'hCAFE_F00D, 32'h0000_1004, 4'b1111, 32'hCAFE_F00D};
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, v[i].size, 1'b0, v[i].addr, v[i].wdata);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL store_req[%0d]: got req=%b we=%b valid=%b expected 1 1 0",
                 i, bus.mem_req, bus.mem_we, bus.resp_valid);
      end
      checks++;
      if (bus.mem_addr !== v[i].exp_addr || bus.mem_wstrb !== v[i].exp_strb ||
          bus.mem_wdata !== v[i].exp_wdata) begin
        failures++;
        $display("FAIL store_bus[%0d]: got addr=%h strb=%b wdata=%h expected %h %b %h",
                 i, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata,
                 v[i].exp_addr, v[i].exp_strb, v[i].exp_wdata);
      end
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b0 || bus.resp_rdata !== 32'h0 ||
          bus.mem_req !== 1'b0) begin
        failures++;
        $display("FAIL store_resp[%0d]: got valid=%b err=%b rdata=%h req=%b expected 1 0 0 0",
                 i, bus.resp_valid, bus.resp_error, bus.resp_rdata, bus.mem_req);
      end
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        failures++;
        $display("FAIL store_after[%0d]: got valid=%b ready=%b expected 0 1",
                 i, bus.resp_valid, bus.req_ready);
      end
    end
  endtask

  task automatic test_load();
    ld_vec_t v[8];
    v[0] = '{2'b01, 1'b0, 32'h0000_2002, 32'h8001_1234, 32'hFFFF_8001};
    v[1] = '{2'b01, 1'b1, 32'h0000_2002, 32'h8001_1234, 32'h0000_8001};
    v[2] = '{2'b01, 1'b0, 32'h0000_2000, 32'h8001_1234, 32'h0000_1234};
    v[3] = '{2'b00, 1'b0, 32'h0000_2003, 32'h8001_1234, 32'hFFFF_FF80};
    v[4] = '{2'b00, 1'b1, 32'h0000_2001, 32'h1234_5678, 32'h0000_0056};
    v[5] = '{2'b00, 1'b0, 32'h0000_2001, 32'h1234_A678, 32'hFFFF_FFA6};
    v[6] = '{2'b10, 1'b0, 32'h0000_2004, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    v[7] = '{2'b10, 1'b1, 32'h0000_2008, 32'h8000_0001, 32'h8000_0001};
    for (int i = 0; i < 8; i++) run_load(v[i], $sformatf("load%0d", i));
  endtask

  task automatic test_error();
    logic [1:0]  sz[5] = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] ad[5] = '{32'h3001, 32'h3002, 32'h3001, 32'h3000, 32'h3003};
    logic        wr[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(wr[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b1 || bus.mem_req !== 1'b0 ||
          bus.resp_rdata !== 32'h0) begin
        failures++;
        $display("FAIL error_resp[%0d]: got valid=%b err=%b req=%b rdata=%h expected 1 1 0 0",
                 i, bus.resp_valid, bus.resp_error, bus.mem_req, bus.resp_rdata);
      end
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
        failures++;
        $display("FAIL error_after[%0d]: got valid=%b ready=%b req=%b expected 0 1 0",
                 i, bus.resp_valid, bus.req_ready, bus.mem_req);
      end
    end
  endtask

  task automatic test_timeout();
    int lat;
    int req_cycles;
    bit got;
    // Grant withheld: mem_req for k+1..k+4, error response at k+5.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
    lat = 1; req_cycles = 0; got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.resp_valid === 1'b1) begin got = 1'b1; break; end
      if (bus.mem_req === 1'b1) req_cycles++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!got || lat != 5 || req_cycles != 4) begin
      failures++;
      $display("FAIL timeout_gnt: got resp=%b at k+%0d with %0d req cycles expected resp at k+5 with 4",
               got, lat, req_cycles);
    end
    checks++;
    if (bus.resp_error !== 1'b1 || bus.resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL timeout_gnt_resp: got err=%b rdata=%h expected 1 0",
               bus.resp_error, bus.resp_rdata);
    end
    @(negedge clk);
    // Grant at k+1, rvalid withheld: WAIT for k+2..k+5, error response at k+6.
    issue(1'b0, 2'b00, 1'b1, 32'h0000_5001, 32'h0);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    lat = 2; req_cycles = 0; got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.resp_valid === 1'b1) begin got = 1'b1; break; end
      if (bus.mem_req === 1'b1) req_cycles++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!got || lat != 6 || req_cycles != 0) begin
      failures++;
      $display("FAIL timeout_rvalid: got resp=%b at k+%0d with %0d req cycles expected resp at k+6 with 0",
               got, lat, req_cycles);
    end
    checks++;
    if (bus.resp_error !== 1'b1 || bus.resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL timeout_rvalid_resp: got err=%b rdata=%h expected 1 0",
               bus.resp_error, bus.resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_stray_rvalid();
    int lat;
    bit got;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h7777_7777;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        failures++;
        $display("FAIL stray_idle[%0d]: got valid=%b ready=%b expected 0 1",
                 n, bus.resp_valid, bus.req_ready);
      end
    end
    bus.mem_rvalid = 1'b0;
    // Word load: junk rvalid in gnt cycle, one idle WAIT cycle, real data at k+3.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_1111;
    @(negedge clk);
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h2222_2222;
    lat = 3; got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      lat++;
      if (bus.resp_valid === 1'b1) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || lat != 4 || bus.resp_rdata !== 32'h2222_2222 || bus.resp_error !== 1'b0) begin
      failures++;
      $display("FAIL stray_load: got resp=%b at k+%0d rdata=%h err=%b expected k+4 22222222 0",
               got, lat, bus.resp_rdata, bus.resp_error);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    // Reset while in WAIT.
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait: got req=%b valid=%b ready=%b expected 0 0 0",
               bus.mem_req, bus.resp_valid, bus.req_ready);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000_00FF;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        failures++;
        $display("FAIL rst_wait_after[%0d]: got valid=%b ready=%b expected 0 1",
                 n, bus.resp_valid, bus.req_ready);
      end
      @(negedge clk);
    end
    // Reset while mem_req is high: it must fall without a clock edge.
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1234_5678);
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_req_pre: got req=%b expected 1", bus.mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_wstrb !== 4'b0000 || bus.mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rst_req_async: got req=%b strb=%b addr=%h expected 0 0000 0",
               bus.mem_req, bus.mem_wstrb, bus.mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_req_after: got valid=%b ready=%b expected 0 1",
               bus.resp_valid, bus.req_ready);
    end
    run_load('{2'b00, 1'b1, 32'h0000_0000, 32'h1234_56C3, 32'h0000_00C3}, "rst_load");
  endtask

  task automatic test_back_to_back();
    // Stores held valid with gnt always high: IDLE, REQ, RESP repeating.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h0000_7000;
    bus.req_wdata = 32'hA5A5_5A5A;
    bus.mem_gnt   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bus.req_ready !== (i % 3 == 0) || bus.resp_valid !== (i % 3 == 2)) begin
        failures++;
        $display("FAIL b2b[%0d]: got ready=%b valid=%b expected %b %b",
                 i, bus.req_ready, bus.resp_valid, (i % 3 == 0), (i % 3 == 2));
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_error();
    test_timeout();
    test_stray_rvalid();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
